uart_rx_param: RTL

- Parametrised UART receiver; successor to the fixed 8N1 `uart` receiver.
- Adds configurable baud divisor, data width, parity and stop-bit count.
- Adds input synchroniser, 3-sample majority voting, false-start rejection, parity/framing error flags and a one-cycle valid strobe.
- Sits between the `rx` pin and byte-consuming logic; the consumer must sample `data` on `valid`.

---
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, 3-sample majority vote per bit,
// false-start rejection, optional parity, 1 or 2 stop bits and a one-cycle valid strobe.
module uart_rx_param #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 sclk,
    input  logic                 srst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS + 1);
    localparam int unsigned H  = CLKS_PER_BIT / 2;

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_S0    = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1    = CW'(H);
    localparam logic [CW-1:0] CNT_MID   = CW'(H + 1);
    localparam logic [IW-1:0] IDX_DLAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_SLAST = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;
    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic                 r_s0;
    logic                 r_s1;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_mis;
    logic                 r_frm_err;

    logic w_start_edge;
    logic w_mid;
    logic w_wrap;
    logic w_bit;
    logic w_par_exp;
    logic w_clear;
    logic w_shift_en;
    logic w_par_set;
    logic w_frm_set;
    logic w_done;

    assign w_start_edge = r_rx_d & ~r_rx_s;
    assign w_mid        = (r_cnt == CNT_MID);
    assign w_wrap       = (r_cnt == CNT_LAST);
    assign w_bit        = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    assign w_par_exp    = (PARITY == 1) ? ~(^r_shift) : (^r_shift);

    // Two-flop synchroniser plus delayed copy for falling-edge detection
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:   if (w_start_edge) w_state_nx = S_START;
            S_START: begin
                if (w_mid && w_bit) begin
                    w_state_nx = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap && (r_idx == IDX_DLAST)) begin
                    w_state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: if (w_wrap) w_state_nx = S_STOP;
            S_STOP:   if (w_mid && (r_idx == IDX_SLAST)) w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    // Per-state datapath strobes; everything acts at the mid-bit vote point
    always_comb begin
        w_clear    = 1'b0;
        w_shift_en = 1'b0;
        w_par_set  = 1'b0;
        w_frm_set  = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE:   w_clear    = w_start_edge;
            S_DATA:   w_shift_en = w_mid;
            S_PARITY: w_par_set  = w_mid && (w_bit != w_par_exp);
            S_STOP: begin
                w_frm_set = w_mid && !w_bit;
                w_done    = w_mid && (r_idx == IDX_SLAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            r_cnt      <= '0;
            r_idx      <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_shift    <= '0;
            r_par_mis  <= 1'b0;
            r_frm_err  <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= w_done;
            busy  <= (w_state_nx != S_IDLE);

            // The detection cycle is bit-time 0 of the start bit
            if (r_state == S_IDLE) begin
                r_cnt <= w_start_edge ? CW'(1) : '0;
            end else if ((w_state_nx == S_IDLE) || w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end

            if (w_state_nx != r_state) begin
                r_idx <= '0;
            end else if (w_wrap) begin
                r_idx <= r_idx + IW'(1);
            end

            if (r_cnt == CNT_S0) r_s0 <= r_rx_s;
            if (r_cnt == CNT_S1) r_s1 <= r_rx_s;

            if (w_clear) begin
                r_par_mis <= 1'b0;
                r_frm_err <= 1'b0;
            end
            if (w_shift_en) r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            if (w_par_set)  r_par_mis <= 1'b1;
            if (w_frm_set)  r_frm_err <= 1'b1;

            if (w_done) begin
                data       <= r_shift;
                parity_err <= r_par_mis;
                frame_err  <= r_frm_err | w_frm_set;
            end
        end
    end

endmodule
